multicycle_controller: RTL and testbench

Parametrised multi-cycle RV32I control unit that sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states. Drives the same datapath control set as the single-cycle controller, plus enables, memory handshakes, a retired-instruction counter and trap detection. Adds optional M-extension decode and a memory-wait timeout. Sits between the instruction register, the memories and the shared datapath (ALU, register file, immediate extender, PC mux).

---
 rtl/rv32_ctrl_pkg.sv | 51 +++++
 rtl/rv32_decode.sv | 90 +++++++++
 rtl/multicycle_controller.sv | 114 +++++++++++
 tb/tb_multicycle_controller.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_ctrl_pkg.sv
// rv32_ctrl_pkg: shared opcodes, control enums and the datapath control vector for the RV32I controllers
package rv32_ctrl_pkg;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_OR, ALU_XOR, ALU_AND, ALU_SLT, ALU_SLTU, ALU_SLL,
        ALU_SRL, ALU_SRA, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_REM
    } alu_op_e;
    typedef enum logic [2:0] {EXT_I, EXT_S, EXT_SHAMT, EXT_U, EXT_B, EXT_J} ext_sel_e;
    typedef enum logic [2:0] {BR_NONE, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU, BR_JUMP} br_type_e;
    typedef enum logic [1:0] {WD_ALU, WD_LOAD, WD_PC4} wdata_sel_e;
    typedef enum logic [1:0] {OPA_RS1, OPA_PC, OPA_ZERO} opa_sel_e;
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_e;
    typedef struct packed {
        logic       rfwrite;
        logic       use_imm;
        ext_sel_e   ext_sel;
        br_type_e   br_type;
        opa_sel_e   sel_pc;
        wdata_sel_e wdata_sel;
        alu_op_e    alu_op;
        logic       mem_en;
        logic       mem_we;
    } ctrl_vec_t;
    // alt only distinguishes SRA from SRL; ADD/SUB selection is left to the caller
    function automatic alu_op_e base_alu(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction
    function automatic logic is_branch(input br_type_e b);
        return b != BR_NONE && b != BR_JUMP;
    endfunction
endpackage

// File: rtl/rv32_decode.sv
// rv32_decode: combinational RV32I(+M) decode of opcode/func3/func7 into a control vector and an illegal flag
module rv32_decode
    import rv32_ctrl_pkg::*;
#(
    parameter bit ENABLE_M = 1'b0
) (
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    output ctrl_vec_t  ctrl,
    output logic       illegal
);
    always_comb begin
        ctrl = '0;
        illegal = 1'b0;
        case (opcode)
            OP_REG: begin
                ctrl.rfwrite = 1'b1;
                if (func7 == F7_BASE)
                    ctrl.alu_op = base_alu(func3, 1'b0);
                else if (func7 == F7_ALT && func3[1:0] == 2'b00 && func3 != 3'b100)
                    ctrl.alu_op = func3[2] ? ALU_SRA : ALU_SUB;
                else if (func7 == F7_ALT && func3 == 3'b101)
                    ctrl.alu_op = ALU_SRA;
                else if (ENABLE_M && func7 == F7_MULDIV)
                    ctrl.alu_op = func3[2] ? (func3[1] ? ALU_REM : ALU_DIV)
                                           : alu_op_e'(4'd10 + {2'b00, func3[1:0]});
                else
                    illegal = 1'b1;
            end
            OP_IMM: begin
                ctrl.rfwrite = 1'b1;
                ctrl.use_imm = 1'b1;
                ctrl.ext_sel = func3[1:0] == 2'b01 ? EXT_SHAMT : EXT_I;
                ctrl.alu_op = base_alu(func3, func7[5]);
                illegal = (func3 == 3'b001 && func7 != F7_BASE) ||
                          (func3 == 3'b101 && func7 != F7_BASE && func7 != F7_ALT);
            end
            OP_LOAD: begin
                ctrl.rfwrite = 1'b1;
                ctrl.use_imm = 1'b1;
                ctrl.wdata_sel = WD_LOAD;
                ctrl.mem_en = 1'b1;
                illegal = func3 == 3'b011 || func3[2:1] == 2'b11;
            end
            OP_STORE: begin
                ctrl.use_imm = 1'b1;
                ctrl.ext_sel = EXT_S;
                ctrl.mem_en = 1'b1;
                ctrl.mem_we = 1'b1;
                illegal = func3[2] || func3 == 3'b011;
            end
            OP_LUI: begin
                ctrl.rfwrite = 1'b1;
                ctrl.use_imm = 1'b1;
                ctrl.ext_sel = EXT_U;
                ctrl.sel_pc = OPA_ZERO;
            end
            OP_AUIPC: begin
                ctrl.rfwrite = 1'b1;
                ctrl.use_imm = 1'b1;
                ctrl.ext_sel = EXT_U;
                ctrl.sel_pc = OPA_PC;
            end
            OP_JAL: begin
                ctrl.rfwrite = 1'b1;
                ctrl.use_imm = 1'b1;
                ctrl.ext_sel = EXT_J;
                ctrl.sel_pc = OPA_PC;
                ctrl.br_type = BR_JUMP;
                ctrl.wdata_sel = WD_PC4;
            end
            OP_JALR: begin
                ctrl.rfwrite = 1'b1;
                ctrl.use_imm = 1'b1;
                ctrl.br_type = BR_JUMP;
                ctrl.wdata_sel = WD_PC4;
                illegal = func3 != 3'b000;
            end
            OP_BRANCH: begin
                ctrl.ext_sel = EXT_B;
                ctrl.alu_op = ALU_SUB;
                ctrl.br_type = func3[2] ? br_type_e'({1'b0, func3[1:0]} + 3'd3)
                                        : (func3[0] ? BR_NE : BR_EQ);
                illegal = func3[2:1] == 2'b01;
            end
            default: illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: FETCH/DECODE/EXEC/MEM/WB sequencer with registered control vector, instret and trap detection
module multicycle_controller
    import rv32_ctrl_pkg::*;
#(
    parameter bit ENABLE_M    = 1'b0,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [2:0]       func3,
    input  logic [6:0]       func7,
    input  logic             br_taken,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             ir_write,
    output logic             pc_write,
    output logic             rfwrite,
    output logic             Use_Imm,
    output logic [2:0]       Extend_sel,
    output logic [2:0]       br_type,
    output logic [1:0]       sel_PC,
    output logic [1:0]       wdata_sel,
    output logic [3:0]       ALUop,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret,
    output logic [2:0]       state_o
);
    localparam int WW = MEM_TIMEOUT > 0 ? $clog2(MEM_TIMEOUT + 1) : 1;
    state_e         state, state_n;
    ctrl_vec_t      ctrl_d, ctrl_q, ctrl_o;
    logic           illegal, tmo, taken_unused;
    logic [1:0]     cause_n;
    logic [WW-1:0]  wait_cnt;
    rv32_decode #(.ENABLE_M(ENABLE_M)) u_dec (
        .opcode (opcode),
        .func3  (func3),
        .func7  (func7),
        .ctrl   (ctrl_d),
        .illegal(illegal)
    );
    // br_taken steers the PC mux in the datapath; the controller retires a branch either way
    assign taken_unused = br_taken;
    assign tmo = MEM_TIMEOUT != 0 && 32'(wait_cnt) == 32'(MEM_TIMEOUT - 1);
    always_comb begin
        state_n = state;
        cause_n = trap_cause;
        imem_req = 1'b0;
        ir_write = 1'b0;
        pc_write = 1'b0;
        dmem_req = 1'b0;
        dmem_we = 1'b0;
        if (!rst) case (state)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_write = imem_ready;
                state_n = imem_ready ? S_DECODE : tmo ? S_TRAP : S_FETCH;
                cause_n = !imem_ready && tmo ? 2'd2 : trap_cause;
            end
            S_DECODE: begin
                state_n = illegal ? S_TRAP : S_EXEC;
                cause_n = illegal ? 2'd1 : trap_cause;
            end
            S_EXEC: begin
                pc_write = is_branch(ctrl_q.br_type);
                state_n = ctrl_q.mem_en ? S_MEM : pc_write ? S_FETCH : S_WB;
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we = ctrl_q.mem_we;
                pc_write = dmem_ready && ctrl_q.mem_we;
                state_n = dmem_ready ? (ctrl_q.mem_we ? S_FETCH : S_WB) : tmo ? S_TRAP : S_MEM;
                cause_n = !dmem_ready && tmo ? 2'd3 : trap_cause;
            end
            S_WB: begin
                pc_write = 1'b1;
                state_n = S_FETCH;
            end
            default: ;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
            ctrl_q <= '0;
            trap_cause <= 2'd0;
            instret <= '0;
            wait_cnt <= '0;
        end else begin
            state <= state_n;
            trap_cause <= cause_n;
            if (state == S_DECODE) ctrl_q <= illegal ? '0 : ctrl_d;
            if (pc_write) instret <= instret + CNT_W'(1);
            // staying in FETCH/MEM implies ready was low this cycle
            wait_cnt <= state_n != state ? '0 :
                        (state == S_FETCH || state == S_MEM) ? wait_cnt + WW'(1) : wait_cnt;
        end
    end
    assign ctrl_o = rst ? '0 : ctrl_q;
    assign rfwrite = ctrl_o.rfwrite && state == S_WB;
    assign Use_Imm = ctrl_o.use_imm;
    assign Extend_sel = ctrl_o.ext_sel;
    assign br_type = ctrl_o.br_type;
    assign sel_PC = ctrl_o.sel_pc;
    assign wdata_sel = ctrl_o.wdata_sel;
    assign ALUop = ctrl_o.alu_op;
    assign trap = !rst && state == S_TRAP;
    assign state_o = state;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed checks of the multicycle controller; u0 (M on, timeout 16), u1 (M off, timeout 4, 3-bit instret)
module tb_multicycle_controller;
    logic clk = 1'b0, rst = 1'b1;
    logic [6:0] opcode = '0, func7 = '0;
    logic [2:0] func3 = '0;
    logic br_taken = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
    logic imem_req, dmem_req, dmem_we, ir_write, pc_write, rfwrite, use_imm, trap;
    logic [2:0] ext_sel, br_type, state_o;
    logic [1:0] sel_pc, wdata_sel, trap_cause;
    logic [3:0] alu_op;
    logic [31:0] instret;
    logic b_imem_req, b_dmem_req, b_dmem_we, b_ir_write, b_pc_write, b_rfwrite, b_use_imm, b_trap;
    logic [2:0] b_ext_sel, b_br_type, b_state_o, b_instret;
    logic [1:0] b_sel_pc, b_wdata_sel, b_trap_cause;
    logic [3:0] b_alu_op;
    int vectors = 0, errors = 0;
    int n_cyc, n_rf, rf_at, n_dreq, n_pcw, n_we, pcw_exec;
    logic [3:0] s_alu;
    logic s_imm;
    logic [2:0] s_ext, s_br;
    logic [1:0] s_sel, s_wd;
    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [3:0] alu;
        logic [2:0] ext;
    } vec_t;
    vec_t tbl[10] = '{
        '{7'b0010011, 3'b010, 7'h00, 4'd5, 3'd0},
        '{7'b0010011, 3'b011, 7'h00, 4'd6, 3'd0},
        '{7'b0010011, 3'b101, 7'h20, 4'd9, 3'd2},
        '{7'b0010011, 3'b101, 7'h00, 4'd8, 3'd2},
        '{7'b0010011, 3'b001, 7'h00, 4'd7, 3'd2},
        '{7'b0010011, 3'b100, 7'h00, 4'd3, 3'd0},
        '{7'b0010011, 3'b110, 7'h00, 4'd2, 3'd0},
        '{7'b0010011, 3'b111, 7'h00, 4'd4, 3'd0},
        '{7'b0110011, 3'b101, 7'h20, 4'd9, 3'd0},
        '{7'b0110011, 3'b011, 7'h00, 4'd6, 3'd0}
    };

    multicycle_controller #(.ENABLE_M(1'b1), .MEM_TIMEOUT(16), .CNT_W(32)) u0 (
        .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7), .br_taken(br_taken),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .ir_write(ir_write), .pc_write(pc_write), .rfwrite(rfwrite), .Use_Imm(use_imm),
        .Extend_sel(ext_sel), .br_type(br_type), .sel_PC(sel_pc), .wdata_sel(wdata_sel), .ALUop(alu_op),
        .trap(trap), .trap_cause(trap_cause), .instret(instret), .state_o(state_o)
    );
    multicycle_controller #(.ENABLE_M(1'b0), .MEM_TIMEOUT(4), .CNT_W(3)) u1 (
        .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7), .br_taken(br_taken),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(b_imem_req), .dmem_req(b_dmem_req),
        .dmem_we(b_dmem_we), .ir_write(b_ir_write), .pc_write(b_pc_write), .rfwrite(b_rfwrite), .Use_Imm(b_use_imm),
        .Extend_sel(b_ext_sel), .br_type(b_br_type), .sel_PC(b_sel_pc), .wdata_sel(b_wdata_sel), .ALUop(b_alu_op),
        .trap(b_trap), .trap_cause(b_trap_cause), .instret(b_instret), .state_o(b_state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required earlier end", $time);
        $fatal(1);
    end

    task automatic do_reset;
        rst = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0; br_taken = 1'b0;
        opcode = '0; func3 = '0; func7 = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // drives one instruction through u0 (u1 follows in lockstep) and records what was observed
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                             input logic bt, input int iwait, input int dwait);
        int fw, mw;
        bit left, done;
        fw = 0; mw = 0; left = 0; done = 0;
        n_cyc = 0; n_rf = 0; rf_at = -1; n_dreq = 0; n_pcw = 0; n_we = 0; pcw_exec = -1;
        opcode = op; func3 = f3; func7 = f7; br_taken = bt;
        for (int k = 0; k < 40 && !done; k++) begin
            imem_ready = state_o == 3'd0 && fw == iwait;
            dmem_ready = state_o == 3'd3 && mw == dwait;
            #1;
            if (rfwrite) begin n_rf++; rf_at = k; end
            if (dmem_req) n_dreq++;
            if (dmem_we) n_we++;
            if (pc_write) n_pcw++;
            if (state_o == 3'd2) begin
                pcw_exec = pc_write ? 1 : 0;
                s_alu = alu_op; s_imm = use_imm; s_ext = ext_sel; s_br = br_type; s_sel = sel_pc; s_wd = wdata_sel;
            end
            if (state_o != 3'd0) left = 1;
            if (state_o == 3'd0) fw++;
            if (state_o == 3'd3) mw++;
            n_cyc = k + 1;
            @(posedge clk);
            #1 done = state_o == 3'd5 || (left && state_o == 3'd0);
        end
        imem_ready = 1'b0; dmem_ready = 1'b0;
        vectors++;
        if (!done) begin errors++; $display("FAIL instr_complete op=%b: got state %0d, required FETCH/TRAP within 40 cycles", op, state_o); end
    endtask

    task automatic test_reset;
        rst = 1'b1; opcode = 7'b0110011; imem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_imem_req got %b exp 0", imem_req); end
        vectors++; if (state_o !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state_o); end
        vectors++; if (instret !== 32'd0) begin errors++; $display("FAIL reset_instret got %0d exp 0", instret); end
        vectors++; if (trap !== 1'b0 || trap_cause !== 2'd0) begin errors++; $display("FAIL reset_trap got %b/%0d exp 0/0", trap, trap_cause); end
        vectors++; if ({ir_write, pc_write, rfwrite, alu_op} !== 7'd0) begin errors++; $display("FAIL reset_outputs got %b exp 0", {ir_write, pc_write, rfwrite, alu_op}); end
        rst = 1'b0; imem_ready = 1'b0;
        #1;
        vectors++; if (imem_req !== 1'b1) begin errors++; $display("FAIL reset_release_imem_req got %b exp 1", imem_req); end
    endtask

    task automatic test_add;
        do_reset();
        run_instr(7'b0110011, 3'b000, 7'h00, 1'b0, 1, 0);
        vectors++; if (rf_at !== 4 || n_rf !== 1) begin errors++; $display("FAIL add_rfwrite got cycle %0d count %0d exp cycle 4 count 1", rf_at, n_rf); end
        vectors++; if (s_alu !== 4'd0) begin errors++; $display("FAIL add_aluop got %0d exp 0", s_alu); end
        vectors++; if (instret !== 32'd1) begin errors++; $display("FAIL add_instret got %0d exp 1", instret); end
        vectors++; if (n_cyc !== 5 || state_o !== 3'd0) begin errors++; $display("FAIL add_sequence got %0d cycles state %0d exp 5 cycles state 0", n_cyc, state_o); end
    endtask

    task automatic test_sub_addi;
        do_reset();
        run_instr(7'b0110011, 3'b000, 7'h20, 1'b0, 0, 0);
        vectors++; if (s_alu !== 4'd1 || s_imm !== 1'b0) begin errors++; $display("FAIL sub_decode got alu %0d imm %b exp 1 0", s_alu, s_imm); end
        run_instr(7'b0010011, 3'b000, 7'h20, 1'b0, 0, 0);
        vectors++; if (s_alu !== 4'd0 || s_imm !== 1'b1 || s_ext !== 3'd0) begin errors++; $display("FAIL addi_decode got alu %0d imm %b ext %0d exp 0 1 0", s_alu, s_imm, s_ext); end
        vectors++; if (instret !== 32'd2) begin errors++; $display("FAIL sub_addi_instret got %0d exp 2", instret); end
    endtask

    task automatic test_alu_table;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            run_instr(tbl[i].op, tbl[i].f3, tbl[i].f7, 1'b0, 0, 0);
            vectors++; if (s_alu !== tbl[i].alu || s_ext !== tbl[i].ext) begin errors++; $display("FAIL alu_table[%0d] got alu %0d ext %0d exp %0d %0d", i, s_alu, s_ext, tbl[i].alu, tbl[i].ext); end
        end
    endtask

    task automatic test_load;
        do_reset();
        run_instr(7'b0000011, 3'b010, 7'h00, 1'b0, 0, 5);
        vectors++; if (n_dreq !== 6 || n_we !== 0) begin errors++; $display("FAIL lw_dmem got req %0d we %0d exp 6 0", n_dreq, n_we); end
        vectors++; if (s_wd !== 2'd1 || s_imm !== 1'b1) begin errors++; $display("FAIL lw_decode got wdata %0d imm %b exp 1 1", s_wd, s_imm); end
        vectors++; if (n_rf !== 1 || instret !== 32'd1) begin errors++; $display("FAIL lw_wb got rf %0d instret %0d exp 1 1", n_rf, instret); end
    endtask

    task automatic test_store;
        do_reset();
        run_instr(7'b0100011, 3'b010, 7'h00, 1'b0, 0, 2);
        vectors++; if (n_dreq !== 3 || n_we !== 3) begin errors++; $display("FAIL sw_dmem got req %0d we %0d exp 3 3", n_dreq, n_we); end
        vectors++; if (n_rf !== 0 || n_pcw !== 1 || s_ext !== 3'd1) begin errors++; $display("FAIL sw_ctrl got rf %0d pcw %0d ext %0d exp 0 1 1", n_rf, n_pcw, s_ext); end
    endtask

    task automatic test_branch;
        do_reset();
        run_instr(7'b1100011, 3'b000, 7'h00, 1'b1, 0, 0);
        vectors++; if (s_br !== 3'd1 || pcw_exec !== 1 || n_rf !== 0 || n_cyc !== 3) begin errors++; $display("FAIL beq got br %0d pcw %0d rf %0d cyc %0d exp 1 1 0 3", s_br, pcw_exec, n_rf, n_cyc); end
        run_instr(7'b1100011, 3'b001, 7'h00, 1'b0, 0, 0);
        vectors++; if (s_br !== 3'd2 || pcw_exec !== 1 || n_rf !== 0) begin errors++; $display("FAIL bne got br %0d pcw %0d rf %0d exp 2 1 0", s_br, pcw_exec, n_rf); end
        vectors++; if (s_alu !== 4'd1 || s_ext !== 3'd4 || instret !== 32'd2) begin errors++; $display("FAIL branch_misc got alu %0d ext %0d instret %0d exp 1 4 2", s_alu, s_ext, instret); end
        run_instr(7'b1100011, 3'b111, 7'h00, 1'b0, 0, 0);
        vectors++; if (s_br !== 3'd6) begin errors++; $display("FAIL bgeu got br %0d exp 6", s_br); end
    endtask

    task automatic test_jump_upper;
        do_reset();
        run_instr(7'b1101111, 3'b000, 7'h00, 1'b0, 0, 0);
        vectors++; if (s_br !== 3'd7 || s_wd !== 2'd2 || s_ext !== 3'd5 || s_sel !== 2'd1) begin errors++; $display("FAIL jal_decode got br %0d wd %0d ext %0d sel %0d exp 7 2 5 1", s_br, s_wd, s_ext, s_sel); end
        vectors++; if (n_rf !== 1 || n_pcw !== 1 || pcw_exec !== 0) begin errors++; $display("FAIL jal_wb got rf %0d pcw %0d pcw_exec %0d exp 1 1 0", n_rf, n_pcw, pcw_exec); end
        run_instr(7'b0110111, 3'b000, 7'h00, 1'b0, 0, 0);
        vectors++; if (s_sel !== 2'd2 || s_ext !== 3'd3 || s_alu !== 4'd0) begin errors++; $display("FAIL lui_decode got sel %0d ext %0d alu %0d exp 2 3 0", s_sel, s_ext, s_alu); end
    endtask

    task automatic test_illegal;
        do_reset();
        run_instr(7'b1100011, 3'b010, 7'h00, 1'b0, 0, 0);
        vectors++; if (trap !== 1'b1 || trap_cause !== 2'd1) begin errors++; $display("FAIL illegal_branch got trap %b cause %0d exp 1 1", trap, trap_cause); end
        vectors++; if (n_pcw !== 0 || instret !== 32'd0) begin errors++; $display("FAIL illegal_retire got pcw %0d instret %0d exp 0 0", n_pcw, instret); end
        imem_ready = 1'b1; dmem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (state_o !== 3'd5 || imem_req !== 1'b0 || trap_cause !== 2'd1) begin errors++; $display("FAIL trap_sticky got state %0d req %b cause %0d exp 5 0 1", state_o, imem_req, trap_cause); end
        do_reset();
        run_instr(7'b0110011, 3'b001, 7'h20, 1'b0, 0, 0);
        vectors++; if (trap_cause !== 2'd1) begin errors++; $display("FAIL illegal_func7 got cause %0d exp 1", trap_cause); end
        do_reset();
        run_instr(7'b1111111, 3'b000, 7'h00, 1'b0, 0, 0);
        vectors++; if (trap_cause !== 2'd1) begin errors++; $display("FAIL illegal_opcode got cause %0d exp 1", trap_cause); end
    endtask

    task automatic test_timeout;
        do_reset();
        run_instr(7'b0010011, 3'b000, 7'h00, 1'b0, 0, 0);
        vectors++; if (b_instret !== 3'd1) begin errors++; $display("FAIL timeout_pre_instret got %0d exp 1", b_instret); end
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (b_state_o !== 3'd0 || b_trap !== 1'b0) begin errors++; $display("FAIL timeout_early got state %0d trap %b exp 0 0", b_state_o, b_trap); end
        @(posedge clk);
        #1;
        vectors++; if (b_trap !== 1'b1 || b_trap_cause !== 2'd2 || b_imem_req !== 1'b0) begin errors++; $display("FAIL imem_timeout got trap %b cause %0d req %b exp 1 2 0", b_trap, b_trap_cause, b_imem_req); end
        vectors++; if (trap !== 1'b0 || state_o !== 3'd0) begin errors++; $display("FAIL long_timeout_dut got trap %b state %0d exp 0 0", trap, state_o); end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        vectors++; if (b_state_o !== 3'd0 || b_trap !== 1'b0 || b_instret !== 3'd0 || b_trap_cause !== 2'd0) begin errors++; $display("FAIL trap_reset got state %0d trap %b instret %0d cause %0d exp 0 0 0 0", b_state_o, b_trap, b_instret, b_trap_cause); end
        vectors++; if (b_imem_req !== 1'b1) begin errors++; $display("FAIL trap_reset_req got %b exp 1", b_imem_req); end
    endtask

    task automatic test_mul;
        do_reset();
        run_instr(7'b0110011, 3'b000, 7'h01, 1'b0, 0, 0);
        vectors++; if (s_alu !== 4'd10 || n_rf !== 1 || trap !== 1'b0 || instret !== 32'd1) begin errors++; $display("FAIL mul_m got alu %0d rf %0d trap %b instret %0d exp 10 1 0 1", s_alu, n_rf, trap, instret); end
        vectors++; if (b_trap !== 1'b1 || b_trap_cause !== 2'd1) begin errors++; $display("FAIL mul_no_m got trap %b cause %0d exp 1 1", b_trap, b_trap_cause); end
        run_instr(7'b0110011, 3'b011, 7'h01, 1'b0, 0, 0);
        vectors++; if (s_alu !== 4'd13) begin errors++; $display("FAIL mulhu got alu %0d exp 13", s_alu); end
        run_instr(7'b0110011, 3'b100, 7'h01, 1'b0, 0, 0);
        vectors++; if (s_alu !== 4'd14) begin errors++; $display("FAIL div got alu %0d exp 14", s_alu); end
        run_instr(7'b0110011, 3'b110, 7'h01, 1'b0, 0, 0);
        vectors++; if (s_alu !== 4'd15) begin errors++; $display("FAIL rem got alu %0d exp 15", s_alu); end
        run_instr(7'b0110011, 3'b000, 7'h02, 1'b0, 0, 0);
        vectors++; if (trap !== 1'b1 || trap_cause !== 2'd1) begin errors++; $display("FAIL bad_func7 got trap %b cause %0d exp 1 1", trap, trap_cause); end
    endtask

    task automatic test_back_to_back;
        do_reset();
        for (int i = 0; i < 8; i++) run_instr(7'b0010011, 3'b000, 7'h00, 1'b0, 0, 0);
        vectors++; if (instret !== 32'd8) begin errors++; $display("FAIL b2b_instret got %0d exp 8", instret); end
        vectors++; if (b_instret !== 3'd0) begin errors++; $display("FAIL instret_wrap got %0d exp 0", b_instret); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_addi();
        test_alu_table();
        test_load();
        test_store();
        test_branch();
        test_jump_upper();
        test_illegal();
        test_timeout();
        test_mul();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
